// File: rtl/chime_scheduler.sv
// Buzzer arbiter for pips, hourly toll and alarm with snooze; all timing from tick_half.
// Define CHIME_RESUME_EN to resume a toll that an alarm preempted.
module chime_scheduler #(
  parameter int PIP_COUNT  = 5,
  parameter int ALARM_SEC  = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       nCLR,
  input  logic       tick_half,
  input  logic       tone_lo,
  input  logic       tone_hi,
  input  logic       req_pip,
  input  logic       req_toll,
  input  logic [3:0] toll_count,
  input  logic       req_alarm,
  input  logic       stop,
  input  logic       snooze,
  input  logic       mute,
  output logic       sound,
  output logic       busy,
  output logic [1:0] active_src,
  output logic       snoozed,
  output logic [1:0] snooze_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PIP    = 3'd1;
  localparam logic [2:0] S_TOLL   = 3'd2;
  localparam logic [2:0] S_ALARM  = 3'd3;
  localparam logic [2:0] S_SNOOZE = 3'd4;

  localparam int PIP_HALVES    = 2 * PIP_COUNT;
  localparam int ALARM_HALVES  = 2 * ALARM_SEC;
  localparam int SNOOZE_HALVES = 2 * SNOOZE_SEC;
  localparam int HMAX_PA = (PIP_HALVES > ALARM_HALVES) ? PIP_HALVES : ALARM_HALVES;
  localparam int HMAX    = (HMAX_PA > 2) ? HMAX_PA : 2;
  localparam int HW      = $clog2(HMAX + 1);
  localparam int SW      = $clog2(SNOOZE_HALVES + 1);

  localparam logic [HW-1:0] PIP_LAST   = HW'(PIP_HALVES - 1);
  localparam logic [HW-1:0] ALARM_LAST = HW'(ALARM_HALVES - 1);
  localparam logic [SW-1:0] SNZ_LOAD   = SW'(SNOOZE_HALVES);

  function automatic logic [3:0] clamp_toll(input logic [3:0] n);
    return (n > 4'd12) ? 4'd12 : n;
  endfunction

  logic [2:0]    state, state_d;
  logic [HW-1:0] half_cnt, half_d;
  logic [3:0]    strikes, strikes_d;
  logic          pend_vld, pend_vld_d;
  logic [3:0]    pend_cnt, pend_cnt_d;
  logic [SW-1:0] snz_left, snz_left_d;
  logic [1:0]    snz_cnt_d;
  logic          from_snz, from_snz_d;
  logic          restart;
  logic          toll_ok;
  logic          snd_lo, snd_hi;
  logic [2:0]    stop_sync, snz_sync;
  logic          stop_ev, snz_ev;
`ifdef CHIME_RESUME_EN
  logic          res_vld, res_vld_d;
  logic [3:0]    res_strikes, res_strikes_d;
`endif

  // Two-flop synchroniser plus rising-edge detect; stop masks a simultaneous snooze.
  always_ff @(posedge clk or negedge nCLR) begin
    if (!nCLR) begin
      stop_sync <= '0;
      snz_sync  <= '0;
    end else begin
      stop_sync <= {stop_sync[1:0], stop};
      snz_sync  <= {snz_sync[1:0], snooze};
    end
  end

  assign stop_ev = stop_sync[1] & ~stop_sync[2];
  assign snz_ev  = snz_sync[1] & ~snz_sync[2] & ~stop_ev;
  assign toll_ok = req_toll && (toll_count != 4'd0);

  always_comb begin
    state_d    = state;
    half_d     = half_cnt;
    strikes_d  = strikes;
    pend_vld_d = pend_vld;
    pend_cnt_d = pend_cnt;
    snz_left_d = snz_left;
    snz_cnt_d  = snooze_cnt;
    from_snz_d = from_snz;
    restart    = 1'b0;
`ifdef CHIME_RESUME_EN
    res_vld_d     = res_vld;
    res_strikes_d = res_strikes;
`endif
    if (mute) begin
      state_d    = S_IDLE;
      pend_vld_d = 1'b0;
      snz_cnt_d  = 2'd0;
      from_snz_d = 1'b0;
`ifdef CHIME_RESUME_EN
      res_vld_d  = 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_alarm) begin
            state_d = S_ALARM;
          end else if (toll_ok) begin
            state_d   = S_TOLL;
            strikes_d = clamp_toll(toll_count);
          end else if (req_pip) begin
            state_d = S_PIP;
          end
        end
        S_PIP: begin
          if (req_alarm) begin
            state_d    = S_ALARM;
            pend_vld_d = 1'b0;
            from_snz_d = 1'b0;
          end else if (stop_ev) begin
            state_d    = S_IDLE;
            pend_vld_d = 1'b0;
            from_snz_d = 1'b0;
            snz_cnt_d  = 2'd0;
          end else begin
            if (toll_ok) begin
              pend_vld_d = 1'b1;
              pend_cnt_d = clamp_toll(toll_count);
            end
            if (tick_half) begin
              if (half_cnt == PIP_LAST) begin
                // A toll queued during the pips follows with no idle cycle.
                if (pend_vld_d) begin
                  state_d    = S_TOLL;
                  strikes_d  = pend_cnt_d;
                  pend_vld_d = 1'b0;
                end else if (from_snz) begin
                  state_d    = S_SNOOZE;
                  from_snz_d = 1'b0;
                end else begin
                  state_d = S_IDLE;
                end
              end else begin
                half_d = half_cnt + HW'(1);
              end
            end
          end
        end
        S_TOLL: begin
          if (req_alarm) begin
            state_d    = S_ALARM;
            pend_vld_d = 1'b0;
            from_snz_d = 1'b0;
`ifdef CHIME_RESUME_EN
            if (!from_snz) begin
              res_vld_d     = 1'b1;
              res_strikes_d = strikes;
            end
`endif
          end else if (stop_ev) begin
            state_d    = S_IDLE;
            pend_vld_d = 1'b0;
            from_snz_d = 1'b0;
            snz_cnt_d  = 2'd0;
          end else if (tick_half) begin
            if (half_cnt[0]) begin
              strikes_d = strikes - 4'd1;
              if (strikes == 4'd1) begin
                state_d    = from_snz ? S_SNOOZE : S_IDLE;
                from_snz_d = 1'b0;
              end
            end
            half_d = half_cnt + HW'(1);
          end
        end
        S_ALARM: begin
          if (stop_ev || (snz_ev && int'(snooze_cnt) >= MAX_SNOOZE) ||
              (!snz_ev && !req_alarm && tick_half && half_cnt == ALARM_LAST)) begin
            snz_cnt_d = 2'd0;
            state_d   = S_IDLE;
`ifdef CHIME_RESUME_EN
            if (res_vld) begin
              state_d   = S_TOLL;
              strikes_d = res_strikes;
              res_vld_d = 1'b0;
            end
`endif
          end else if (snz_ev) begin
            snz_cnt_d  = snooze_cnt + 2'd1;
            snz_left_d = SNZ_LOAD;
            state_d    = S_SNOOZE;
          end else if (req_alarm) begin
            restart = 1'b1;
          end else if (tick_half) begin
            half_d = half_cnt + HW'(1);
          end
        end
        S_SNOOZE: begin
          if (stop_ev) begin
            state_d   = S_IDLE;
            snz_cnt_d = 2'd0;
`ifdef CHIME_RESUME_EN
            res_vld_d = 1'b0;
`endif
          end else if (req_alarm) begin
            state_d = S_ALARM;
          end else if (toll_ok) begin
            state_d    = S_TOLL;
            strikes_d  = clamp_toll(toll_count);
            from_snz_d = 1'b1;
          end else if (req_pip) begin
            state_d    = S_PIP;
            from_snz_d = 1'b1;
`ifdef CHIME_RESUME_EN
          end else if (res_vld) begin
            state_d    = S_TOLL;
            strikes_d  = res_strikes;
            res_vld_d  = 1'b0;
            from_snz_d = 1'b1;
`endif
          end else if (tick_half) begin
            snz_left_d = snz_left - SW'(1);
            if (snz_left == SW'(1)) state_d = S_ALARM;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (restart || state_d != state) half_d = '0;
  end

  // State and outputs register together so outputs track the state they decode.
  always_ff @(posedge clk or negedge nCLR) begin
    if (!nCLR) begin
      state      <= S_IDLE;
      half_cnt   <= '0;
      strikes    <= '0;
      pend_vld   <= 1'b0;
      pend_cnt   <= '0;
      snz_left   <= '0;
      snooze_cnt <= '0;
      from_snz   <= 1'b0;
      snd_lo     <= 1'b0;
      snd_hi     <= 1'b0;
      busy       <= 1'b0;
      active_src <= 2'b00;
      snoozed    <= 1'b0;
`ifdef CHIME_RESUME_EN
      res_vld     <= 1'b0;
      res_strikes <= '0;
`endif
    end else begin
      state      <= state_d;
      half_cnt   <= half_d;
      strikes    <= strikes_d;
      pend_vld   <= pend_vld_d;
      pend_cnt   <= pend_cnt_d;
      snz_left   <= snz_left_d;
      snooze_cnt <= snz_cnt_d;
      from_snz   <= from_snz_d;
      snd_lo     <= (state_d == S_PIP || state_d == S_TOLL) && !half_d[0];
      snd_hi     <= (state_d == S_ALARM) && !half_d[0];
      busy       <= (state_d != S_IDLE);
      snoozed    <= (state_d == S_SNOOZE);
      case (state_d)
        S_PIP:   active_src <= 2'b01;
        S_TOLL:  active_src <= 2'b10;
        S_ALARM: active_src <= 2'b11;
        default: active_src <= 2'b00;
      endcase
`ifdef CHIME_RESUME_EN
      res_vld     <= res_vld_d;
      res_strikes <= res_strikes_d;
`endif
    end
  end

  assign sound = ~mute & ((snd_lo & tone_lo) | (snd_hi & tone_hi));

endmodule
